// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter that shares one register-file write port between two
// write-back requesters. Each requester feeds a small FIFO. Define FWD_EN to add the forwarding lookup ports.
module reg_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          req0_valid_i,
    input  logic [AW-1:0] req0_addr_i,
    input  logic [DW-1:0] req0_data_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic [AW-1:0] req1_addr_i,
    input  logic [DW-1:0] req1_data_i,
    output logic          req1_ready_o,
    output logic          RegWrite_o,
    output logic [AW-1:0] RDaddr_o,
    output logic [DW-1:0] RDdata_o,
    output logic          busy_o
`ifdef FWD_EN
    ,
    input  logic [AW-1:0] fwd_addr_i,
    output logic          fwd_hit_o,
    output logic [DW-1:0] fwd_data_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_addr [2][DEPTH];
    logic [DW-1:0] q_data [2][DEPTH];
    logic [PW-1:0] wp     [2];
    logic [PW-1:0] rp     [2];
    logic [CW-1:0] cnt    [2];

    logic [AW-1:0] in_addr [2];
    logic [DW-1:0] in_data [2];
    logic [1:0]    in_valid;
    logic [1:0]    ready;
    logic [1:0]    nonempty;
    logic [1:0]    push;
    logic [1:0]    grant;
    logic          rr;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        in_valid   = {req1_valid_i, req0_valid_i};
        in_addr[0] = req0_addr_i;
        in_addr[1] = req1_addr_i;
        in_data[0] = req0_data_i;
        in_data[1] = req1_data_i;
        for (int r = 0; r < 2; r++) begin
            ready[r]    = (cnt[r] != CW'(DEPTH));
            nonempty[r] = (cnt[r] != '0);
        end
        push = in_valid & ready;
    end

    always_comb begin
        if (nonempty == 2'b11) begin
            grant = rr ? 2'b10 : 2'b01;
        end else begin
            grant = nonempty;
        end
        head_addr = grant[1] ? q_addr[1][rp[1]] : q_addr[0][rp[0]];
        head_data = grant[1] ? q_data[1][rp[1]] : q_data[0][rp[0]];
    end

    assign req0_ready_o = ready[0];
    assign req1_ready_o = ready[1];
    assign busy_o       = (|nonempty) | RegWrite_o;

    // NOTE: FIFO storage is deliberately not reset; validity comes from the reset pointers and counts.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                q_addr[r][wp[r]] <= in_addr[r];
                q_data[r][wp[r]] <= in_data[r];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 2; r++) begin
                wp[r]  <= '0;
                rp[r]  <= '0;
                cnt[r] <= '0;
            end
            rr         <= 1'b0;
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) wp[r] <= wp[r] + PW'(1);
                if (grant[r]) rp[r] <= rp[r] + PW'(1);
                if (push[r] && !grant[r]) begin
                    cnt[r] <= cnt[r] + CW'(1);
                end else if (!push[r] && grant[r]) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
            if (|grant) begin
                // Point rr at the requester that was not served.
                rr         <= grant[0];
                RDaddr_o   <= head_addr;
                RDdata_o   <= head_data;
                RegWrite_o <= (head_addr != '0);
            end else begin
                RegWrite_o <= 1'b0;
            end
        end
    end

`ifdef FWD_EN
    // Scan lowest priority first so later matches override: output stage,
    // then req1 oldest..newest, then req0 oldest..newest.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_addr_i != '0) begin
            if (RegWrite_o && (RDaddr_o == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = RDdata_o;
            end
            for (int r = 1; r >= 0; r--) begin
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    idx = wp[r] - PW'(i + 1);
                    if ((CW'(i) < cnt[r]) && (q_addr[r][idx] == fwd_addr_i)) begin
                        fwd_hit_o  = 1'b1;
                        fwd_data_o = q_data[r][idx];
                    end
                end
            end
        end
    end
`else
    // Without forwarding, FIFO contents are only ever read at the head.
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed testbench for reg_wb_arbiter: reset, single write, contention,
// FIFO full back-pressure, r0 suppression and (with FWD_EN) forwarding.
module tb_reg_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          reg_write;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
`ifdef FWD_EN
    logic [AW-1:0] fwd_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] rf [32];

    int src0[$];
    int src1[$];
    int got_addr[$];
    logic [DW-1:0] got_data[$];
    logic rdy1_hist[$];

    reg_wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_addr_i  (req0_addr),
        .req0_data_i  (req0_data),
        .req0_ready_o (req0_ready),
        .req1_valid_i (req1_valid),
        .req1_addr_i  (req1_addr),
        .req1_data_i  (req1_data),
        .req1_ready_o (req1_ready),
        .RegWrite_o   (reg_write),
        .RDaddr_o     (rd_addr),
        .RDdata_o     (rd_data),
        .busy_o       (busy)
`ifdef FWD_EN
        ,
        .fwd_addr_i   (fwd_addr),
        .fwd_hit_o    (fwd_hit),
        .fwd_data_o   (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Register file model: samples the write port on the falling edge.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(negedge clk) if (reg_write) rf[rd_addr] <= rd_data;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step();
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", reg_write); end
        checks++; if (rd_addr !== '0) begin failures++; $display("FAIL reset_rdaddr got=%0d exp=0", rd_addr); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rddata got=%h exp=0", rd_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({req1_ready, req0_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", {req1_ready, req0_ready}); end
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0333;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0444;
        for (int i = 0; i < 5; i++) step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL traffic_busy got=%b exp=1", busy); end
        checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL traffic_regwrite got=%b exp=1", reg_write); end
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL midreset_regwrite got=%b exp=0", reg_write); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if ({req1_ready, req0_ready} !== 2'b11) begin failures++; $display("FAIL midreset_ready got=%b exp=11", {req1_ready, req0_ready}); end
        checks++; if (rd_addr !== '0) begin failures++; $display("FAIL midreset_rdaddr got=%0d exp=0", rd_addr); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (reg_write !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL stale_after_reset cyc=%0d regwrite=%b busy=%b exp=0,0", i, reg_write, busy);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
        step();
        req0_valid = 1'b0;
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL single_early_regwrite got=%b exp=0", reg_write); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        step();
        checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", reg_write, rd_addr, rd_data);
        end
        step();
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b exp=0", reg_write); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        checks++; if (rd_addr !== 5'd5) begin failures++; $display("FAIL single_addr_hold got=%0d exp=5", rd_addr); end
        checks++; if (rf[5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rf5 got=%h exp=deadbeef", rf[5]); end
    endtask

    // Streams src0/src1 through the handshake, honouring ready; records every write.
    task automatic run_stream(input int max_cycles);
        int  i0;
        int  i1;
        int  cyc;
        logic acc0;
        logic acc1;
        i0 = 0; i1 = 0; cyc = 0;
        got_addr.delete(); got_data.delete(); rdy1_hist.delete();
        req0_valid = (src0.size() > 0);
        req1_valid = (src1.size() > 0);
        if (req0_valid) begin req0_addr = AW'(src0[0]); req0_data = 32'hA000_0000 | src0[0]; end
        if (req1_valid) begin req1_addr = AW'(src1[0]); req1_data = 32'hB000_0000 | src1[0]; end
        while (cyc < max_cycles) begin
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            step();
            cyc++;
            if (acc0) i0++;
            if (acc1) i1++;
            rdy1_hist.push_back(req1_ready);
            if (reg_write) begin
                got_addr.push_back(int'(rd_addr));
                got_data.push_back(rd_data);
            end
            req0_valid = (i0 < src0.size());
            req1_valid = (i1 < src1.size());
            if (req0_valid) begin req0_addr = AW'(src0[i0]); req0_data = 32'hA000_0000 | src0[i0]; end
            if (req1_valid) begin req1_addr = AW'(src1[i1]); req1_data = 32'hB000_0000 | src1[i1]; end
            if (!req0_valid && !req1_valid && !busy) break;
        end
        checks++; if (cyc >= max_cycles) begin failures++; $display("FAIL stream_timeout cycles=%0d limit=%0d", cyc, max_cycles); end
    endtask

    task automatic compare_seq(input string name, input int exp_addr[$], input logic exp_src1[$]);
        logic [DW-1:0] exp_data;
        checks++; if (got_addr.size() !== exp_addr.size()) begin
            failures++; $display("FAIL %s_count got=%0d exp=%0d", name, got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            exp_data = (exp_src1[i] ? 32'hB000_0000 : 32'hA000_0000) | exp_addr[i];
            checks++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data) begin
                failures++; $display("FAIL %s[%0d] got=%0d/%h exp=%0d/%h", name, i, got_addr[i], got_data[i], exp_addr[i], exp_data);
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        src0 = '{1, 2, 3};
        src1 = '{9, 10, 11};
        run_stream(40);
        compare_seq("contention", '{1, 9, 2, 10, 3, 11}, '{0, 1, 0, 1, 0, 1});
    endtask

    task automatic test_full();
        do_reset();
        src0 = '{1, 2, 3, 4, 5, 6};
        src1 = '{16, 17, 18, 19};
        run_stream(60);
        checks++; if (rdy1_hist.size() < 2 || rdy1_hist[1] !== 1'b0) begin
            failures++; $display("FAIL full_ready1_after_2_pushes got=%b exp=0", (rdy1_hist.size() < 2) ? 1'bx : rdy1_hist[1]);
        end
        compare_seq("full", '{1, 16, 2, 17, 3, 18, 4, 19, 5, 6}, '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0});
    endtask

    task automatic test_r0();
        do_reset();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", req1_ready); end
        step();
        req1_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL r0_queued_busy got=%b exp=1", busy); end
        step();
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL r0_suppressed got=%b exp=0", reg_write); end
        checks++; if (rd_data !== 32'h0000_1234) begin failures++; $display("FAIL r0_data_loaded got=%h exp=00001234", rd_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL r0_consumed_busy got=%b exp=0", busy); end
        step();
        checks++; if (rf[0] !== '0) begin failures++; $display("FAIL r0_rf got=%h exp=0", rf[0]); end
    endtask

`ifdef FWD_EN
    task automatic test_fwd();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_00AA;
        step();
        req0_valid = 1'b0;
        fwd_addr = 5'd7;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000_00AA) begin
            failures++; $display("FAIL fwd_hit got=%b/%h exp=1/000000aa", fwd_hit, fwd_data);
        end
        fwd_addr = 5'd0;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin
            failures++; $display("FAIL fwd_r0 got=%b/%h exp=0/0", fwd_hit, fwd_data);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_r0();
`ifdef FWD_EN
        test_fwd();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
